// File: rtl/sorting_network_pkg.sv
// Shared helpers for the key/payload/index odd-even transposition sorter.
package sorting_network_pkg;

    localparam int unsigned KEY_MAX = 64;

    function automatic int unsigned num_stages(input int unsigned lanes, input int unsigned layers);
        return (lanes + layers - 1) / layers;
    endfunction

    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Keys arrive zero-extended; a signed compare becomes unsigned once the sign bits are flipped.
    function automatic logic cas_swap(
        input logic [KEY_MAX-1:0] key_lo,
        input logic [KEY_MAX-1:0] key_hi,
        input logic               dir,
        input logic               signed_keys,
        input int unsigned        width
    );
        logic [KEY_MAX-1:0] flip;
        logic [KEY_MAX-1:0] a;
        logic [KEY_MAX-1:0] b;
        flip = signed_keys ? (KEY_MAX'(1) << (width - 1)) : '0;
        a    = key_lo ^ flip;
        b    = key_hi ^ flip;
        return dir ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sorting_network_layer.sv
// One combinational odd or even compare-and-swap layer over all lanes.
module sorting_network_layer
    import sorting_network_pkg::*;
#(
    parameter int unsigned NUMBERS_AMOUNT = 10,
    parameter int unsigned KEY_WIDTH      = 10,
    parameter int unsigned PAYLOAD_WIDTH  = 8,
    parameter int unsigned IDX_W          = 4,
    parameter bit          SIGNED_KEYS    = 1'b0,
    parameter bit          ODD            = 1'b1,
    localparam int unsigned LANE_W        = KEY_WIDTH + PAYLOAD_WIDTH + IDX_W
) (
    input  logic                             dir,
    input  logic [NUMBERS_AMOUNT*LANE_W-1:0] lanes_in,
    output logic [NUMBERS_AMOUNT*LANE_W-1:0] lanes_out
);

    typedef struct packed {
        logic [KEY_WIDTH-1:0]     key;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [IDX_W-1:0]         index;
    } lane_t;

    localparam int unsigned FIRST = ODD ? 0 : 1;

    lane_t [NUMBERS_AMOUNT-1:0] lin;
    lane_t [NUMBERS_AMOUNT-1:0] lout;

    assign lin       = lanes_in;
    assign lanes_out = lout;

    for (genvar p = FIRST; p + 1 < NUMBERS_AMOUNT; p += 2) begin : g_pair
        logic swap;
        assign swap        = cas_swap(KEY_MAX'(lin[p].key), KEY_MAX'(lin[p+1].key),
                                      dir, SIGNED_KEYS, KEY_WIDTH);
        assign lout[p]     = swap ? lin[p+1] : lin[p];
        assign lout[p+1]   = swap ? lin[p]   : lin[p+1];
    end

    if (!ODD) begin : g_low_edge
        assign lout[0] = lin[0];
    end

    if ((NUMBERS_AMOUNT - FIRST) % 2 == 1) begin : g_high_edge
        assign lout[NUMBERS_AMOUNT-1] = lin[NUMBERS_AMOUNT-1];
    end

endmodule

// File: rtl/sorting_network_kv.sv
// Pipelined odd-even transposition sorter carrying payload and origin lane with each key.
module sorting_network_kv
    import sorting_network_pkg::*;
#(
    parameter int unsigned KEY_WIDTH        = 10,
    parameter int unsigned PAYLOAD_WIDTH    = 8,
    parameter int unsigned NUMBERS_AMOUNT   = 10,
    parameter int unsigned LAYERS_PER_STAGE = 1,
    parameter bit          SIGNED_KEYS      = 1'b0,
    localparam int unsigned IDX_W           = idx_width(NUMBERS_AMOUNT)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUMBERS_AMOUNT*KEY_WIDTH-1:0]     data_i,
    input  logic [NUMBERS_AMOUNT*PAYLOAD_WIDTH-1:0] payload_i,
    input  logic                                   dir_i,
    input  logic                                   data_valid_i,
    output logic                                   ready_o,
    output logic [NUMBERS_AMOUNT*KEY_WIDTH-1:0]     data_o,
    output logic [NUMBERS_AMOUNT*PAYLOAD_WIDTH-1:0] payload_o,
    output logic [NUMBERS_AMOUNT*IDX_W-1:0]         index_o,
    output logic                                   data_valid_o,
    input  logic                                   ready_i
);

    localparam int unsigned NUM_STAGES = num_stages(NUMBERS_AMOUNT, LAYERS_PER_STAGE);
    localparam int unsigned LANE_W     = KEY_WIDTH + PAYLOAD_WIDTH + IDX_W;
    localparam int unsigned LANES_W    = NUMBERS_AMOUNT * LANE_W;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]     key;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [IDX_W-1:0]         index;
    } lane_t;

    lane_t [NUMBERS_AMOUNT-1:0] in_lanes;
    lane_t [NUMBERS_AMOUNT-1:0] out_lanes;

    logic [NUM_STAGES:0][LANES_W-1:0]     stage_data;
    logic [NUM_STAGES:0][LANES_W-1:0]     stage_next;
    logic [NUM_STAGES:0]                  stage_valid;
    logic [NUM_STAGES-1:0]                stage_dir;
    logic [NUM_STAGES-1:0]                dir_next;
    logic [NUMBERS_AMOUNT:1][LANES_W-1:0] layer_out;

    assign data_valid_o = stage_valid[NUM_STAGES];
    assign ready_o      = ready_i | ~data_valid_o;
    assign out_lanes    = stage_data[NUM_STAGES];

    for (genvar i = 0; i < NUMBERS_AMOUNT; i++) begin : g_lane
        assign in_lanes[i].key     = data_i[i*KEY_WIDTH +: KEY_WIDTH];
        assign in_lanes[i].payload = payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        assign in_lanes[i].index   = IDX_W'(i);
        assign data_o[i*KEY_WIDTH +: KEY_WIDTH]             = out_lanes[i].key;
        assign payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]   = out_lanes[i].payload;
        assign index_o[i*IDX_W +: IDX_W]                    = out_lanes[i].index;
    end

    // Layer k reads its stage register when it starts a stage, otherwise the previous layer.
    for (genvar k = 1; k <= NUMBERS_AMOUNT; k++) begin : g_layer
        localparam int unsigned STAGE = (k - 1) / LAYERS_PER_STAGE;
        logic [LANES_W-1:0] layer_in;
        if ((k - 1) % LAYERS_PER_STAGE == 0) begin : g_head
            assign layer_in = stage_data[STAGE];
        end else begin : g_chain
            assign layer_in = layer_out[k-1];
        end
        sorting_network_layer #(
            .NUMBERS_AMOUNT(NUMBERS_AMOUNT),
            .KEY_WIDTH     (KEY_WIDTH),
            .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
            .IDX_W         (IDX_W),
            .SIGNED_KEYS   (SIGNED_KEYS),
            .ODD           (k % 2 == 1)
        ) u_layer (
            .dir      (stage_dir[STAGE]),
            .lanes_in (layer_in),
            .lanes_out(layer_out[k])
        );
    end

    assign stage_next[0] = in_lanes;
    assign dir_next[0]   = dir_i;

    for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
        localparam int unsigned LAST = (s * LAYERS_PER_STAGE < NUMBERS_AMOUNT) ?
                                       s * LAYERS_PER_STAGE : NUMBERS_AMOUNT;
        assign stage_next[s] = layer_out[LAST];
        if (s < NUM_STAGES) begin : g_dir
            assign dir_next[s] = stage_dir[s-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_data  <= '0;
            stage_dir   <= '0;
            stage_valid <= '0;
        end else if (ready_o) begin
            stage_data  <= stage_next;
            stage_dir   <= dir_next;
            stage_valid <= {stage_valid[NUM_STAGES-1:0], data_valid_i};
        end
    end

endmodule
